// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
// Decode-stage control unit for the pipelined RV32 core. Decodes the IF/ID
// instruction into a control bundle and registers it into the ID/EX control
// register. Inserts bubbles for load-use hazards and taken branches/jumps,
// and holds the pipe while a multi-cycle MUL/DIV occupies EX.
//
// Ports
//   clk, rst          core clock (rising edge), async active-high reset
//   inst_i            IF/ID instruction
//   inst_valid_i      IF/ID slot holds a real instruction
//   flush_i           branch/jump taken in EX; kill the ID instruction
//   ex_*_o            registered ID/EX control bundle
//   stall_o           hold PC and IF/ID this cycle (combinational)
//   md_busy_o         MUL/DIV occupying EX
//   md_done_o         pulse in the last MUL/DIV cycle (combinational)
//
// State table
//   state | meaning
//   IDLE  | normal decode; ID/EX loads every cycle (instruction or bubble)
//   BUSY  | MUL/DIV in EX; ID/EX held, cnt counts down to the last cycle
//
// XLEN is carried for interface compatibility; only 32 is meaningful.
// ---------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1,
    parameter int MD_LAT   = 4,
    parameter int CNT_W    = $clog2(MD_LAT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] inst_i,
    input  logic            inst_valid_i,
    input  logic            flush_i,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            ex_mem_to_reg_o,
    output logic            ex_reg_write_o,
    output logic            ex_branch_o,
    output logic            ex_pc_src_o,
    output logic [2:0]      ex_alu_op_o,
    output logic [1:0]      ex_alu_src_o,
    output logic [1:0]      ex_alu_src1_o,
    output logic            ex_sign_o,
    output logic [1:0]      ex_length_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_valid_o,
    output logic            stall_o,
    output logic            md_busy_o,
    output logic            md_done_o
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_ILOAD  = 7'b0000011;
    localparam logic [6:0] OP_STYPE  = 7'b0100011;
    localparam logic [6:0] OP_BTYPE  = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_R      = 3'd0;
    localparam logic [2:0] ALU_I      = 3'd1;
    localparam logic [2:0] ALU_LS     = 3'd2;
    localparam logic [2:0] ALU_BRANCH = 3'd3;
    localparam logic [2:0] ALU_J      = 3'd4;
    localparam logic [2:0] ALU_U      = 3'd5;
    localparam logic [2:0] ALU_MD     = 3'd6;

    localparam logic [1:0] SRC2_REG  = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;
    localparam logic [1:0] SRC1_REG  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;

    typedef struct packed {
        logic       valid;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       pc_src;
        logic [2:0] alu_op;
        logic [1:0] alu_src;
        logic [1:0] alu_src1;
        logic       sign;
        logic [1:0] length;
        logic [4:0] rd;
    } ctl_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];

    ctl_t             dec;
    ctl_t             ex;
    logic             use_rs1;
    logic             use_rs2;
    logic             is_md;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        dec           = '0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        is_md         = 1'b0;
        dec.valid     = 1'b1;
        dec.rd        = inst_i[11:7];
        dec.sign      = ~funct3[2];
        dec.reg_write = 1'b1;
        dec.alu_src   = SRC2_FOUR;
        dec.alu_src1  = SRC1_PC;
        case (funct3)
            3'b010:         dec.length = 2'd2;
            3'b001, 3'b101: dec.length = 2'd1;
            default:        dec.length = 2'd0;
        endcase
        case (opcode)
            OP_RTYPE: begin
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec.alu_src  = SRC2_REG;
                dec.alu_src1 = SRC1_REG;
                is_md        = (ENABLE_M != 0) && (funct7 == 7'b0000001);
                dec.alu_op   = is_md ? ALU_MD : ALU_R;
            end
            OP_IARITH: begin
                use_rs1      = 1'b1;
                dec.alu_src  = SRC2_IMM;
                dec.alu_src1 = SRC1_REG;
                dec.alu_op   = ALU_I;
            end
            OP_ILOAD: begin
                use_rs1        = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = SRC2_IMM;
                dec.alu_src1   = SRC1_REG;
                dec.alu_op     = ALU_LS;
            end
            OP_STYPE: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.mem_write = 1'b1;
                dec.reg_write = 1'b0;
                dec.alu_src   = SRC2_IMM;
                dec.alu_src1  = SRC1_REG;
                dec.alu_op    = ALU_LS;
            end
            OP_BTYPE: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.branch    = 1'b1;
                dec.reg_write = 1'b0;
                dec.alu_src   = SRC2_REG;
                dec.alu_src1  = SRC1_REG;
                dec.alu_op    = ALU_BRANCH;
            end
            OP_JAL: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_J;
            end
            OP_JALR: begin
                use_rs1    = 1'b1;
                dec.branch = 1'b1;
                dec.pc_src = 1'b1;
                dec.alu_op = ALU_J;
            end
            OP_LUI: begin
                dec.alu_src  = SRC2_IMM;
                dec.alu_src1 = SRC1_ZERO;
                dec.alu_op   = ALU_U;
            end
            OP_AUIPC: begin
                dec.alu_src = SRC2_IMM;
                dec.alu_op  = ALU_U;
            end
            default: ;
        endcase
    end

    logic load_use;
    logic issue_md;

    // rd = x0 never creates a dependency, so it cannot cause a stall.
    assign load_use = inst_valid_i && ex.valid && ex.mem_read && (ex.rd != 5'd0) &&
                      ((use_rs1 && (rs1 == ex.rd)) || (use_rs2 && (rs2 == ex.rd)));
    assign issue_md = inst_valid_i && is_md && !load_use && !flush_i && (state == IDLE);

    // A flush kills whatever is in ID, so holding IF/ID would be pointless.
    assign stall_o   = !flush_i && ((state == BUSY) || load_use);
    assign md_busy_o = (state == BUSY);
    assign md_done_o = !flush_i &&
                       (((state == BUSY) && (cnt == CNT_W'(1))) || ((MD_LAT == 1) && issue_md));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ex    <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
            ex    <= '0;
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state <= IDLE;
            end
        end else if (load_use || !inst_valid_i) begin
            ex <= '0;
        end else begin
            ex <= dec;
            if (is_md) begin
                cnt <= CNT_W'(MD_LAT - 1);
                if (MD_LAT > 1) begin
                    state <= BUSY;
                end
            end
        end
    end

    assign ex_valid_o      = ex.valid;
    assign ex_mem_read_o   = ex.mem_read;
    assign ex_mem_write_o  = ex.mem_write;
    assign ex_mem_to_reg_o = ex.mem_to_reg;
    assign ex_reg_write_o  = ex.reg_write;
    assign ex_branch_o     = ex.branch;
    assign ex_pc_src_o     = ex.pc_src;
    assign ex_alu_op_o     = ex.alu_op;
    assign ex_alu_src_o    = ex.alu_src;
    assign ex_alu_src1_o   = ex.alu_src1;
    assign ex_sign_o       = ex.sign;
    assign ex_length_o     = ex.length;
    assign ex_rd_o         = ex.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_unit
// Drives three instances from one stimulus stream:
//   0: ENABLE_M=1, MD_LAT=4   1: ENABLE_M=0, MD_LAT=4   2: ENABLE_M=1, MD_LAT=1
// Each instance is compared every cycle with a per-instance reference model
// (instruction-class decode table, EX slot contents, remaining hold cycles).
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_unit;
    localparam int NDUT = 3;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic       mr;
        logic       mw;
        logic       mtr;
        logic       rw;
        logic       br;
        logic       pcs;
        logic [2:0] aluop;
        logic [1:0] src;
        logic [1:0] src1;
        logic       sign;
        logic [1:0] len;
        logic [4:0] rd;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        flush;

    logic       o_mr [NDUT], o_mw [NDUT], o_mtr [NDUT], o_rw [NDUT], o_br [NDUT], o_pcs [NDUT];
    logic [2:0] o_aluop [NDUT];
    logic [1:0] o_src [NDUT], o_src1 [NDUT], o_len [NDUT];
    logic       o_sign [NDUT], o_valid [NDUT], o_stall [NDUT], o_busy [NDUT], o_done [NDUT];
    logic [4:0] o_rd [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipe_ctrl_unit #(
            .XLEN     (32),
            .ENABLE_M ((g == 1) ? 0 : 1),
            .MD_LAT   ((g == 2) ? 1 : 4)
        ) dut (
            .clk             (clk),
            .rst             (rst),
            .inst_i          (inst),
            .inst_valid_i    (inst_valid),
            .flush_i         (flush),
            .ex_mem_read_o   (o_mr[g]),
            .ex_mem_write_o  (o_mw[g]),
            .ex_mem_to_reg_o (o_mtr[g]),
            .ex_reg_write_o  (o_rw[g]),
            .ex_branch_o     (o_br[g]),
            .ex_pc_src_o     (o_pcs[g]),
            .ex_alu_op_o     (o_aluop[g]),
            .ex_alu_src_o    (o_src[g]),
            .ex_alu_src1_o   (o_src1[g]),
            .ex_sign_o       (o_sign[g]),
            .ex_length_o     (o_len[g]),
            .ex_rd_o         (o_rd[g]),
            .ex_valid_o      (o_valid[g]),
            .stall_o         (o_stall[g]),
            .md_busy_o       (o_busy[g]),
            .md_done_o       (o_done[g])
        );
    end

    int vectors     = 0;
    int miscompares = 0;

    ctl_t m_ex [NDUT];
    int   m_left [NDUT];
    logic ls_stall [NDUT], ls_busy [NDUT], ls_done [NDUT];

    function automatic bit cfg_en(int i);
        return (i != 1);
    endfunction

    function automatic int cfg_lat(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic bit uses_rs1(logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR};
    endfunction

    function automatic bit uses_rs2(logic [6:0] op);
        return op inside {OP_R, OP_ST, OP_BR};
    endfunction

    // Reference decode: instruction class -> control bundle.
    function automatic ctl_t ref_decode(logic [31:0] ins, bit en_m);
        ctl_t       c;
        logic [2:0] f3;
        f3      = ins[14:12];
        c       = '0;
        c.valid = 1'b1;
        c.rd    = ins[11:7];
        c.sign  = !f3[2];
        c.len   = (f3 == 3'b010) ? 2'd2 : ((f3 == 3'b001 || f3 == 3'b101) ? 2'd1 : 2'd0);
        c.rw    = 1'b1;
        c.src   = 2'd2;
        c.src1  = 2'd1;
        case (ins[6:0])
            OP_R:    begin c.src = 0; c.src1 = 0; c.aluop = (en_m && ins[31:25] == 7'd1) ? 3'd6 : 3'd0; end
            OP_I:    begin c.src = 1; c.src1 = 0; c.aluop = 3'd1; end
            OP_LD:   begin c.mr = 1; c.mtr = 1; c.src = 1; c.src1 = 0; c.aluop = 3'd2; end
            OP_ST:   begin c.mw = 1; c.rw = 0; c.src = 1; c.src1 = 0; c.aluop = 3'd2; end
            OP_BR:   begin c.br = 1; c.rw = 0; c.src = 0; c.src1 = 0; c.aluop = 3'd3; end
            OP_JAL:  begin c.br = 1; c.aluop = 3'd4; end
            OP_JALR: begin c.br = 1; c.pcs = 1; c.aluop = 3'd4; end
            OP_LUI:  begin c.src = 1; c.src1 = 2; c.aluop = 3'd5; end
            OP_AUI:  begin c.src = 1; c.aluop = 3'd5; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t obs_ctl(int i);
        ctl_t c;
        c.valid = o_valid[i];
        c.mr    = o_mr[i];
        c.mw    = o_mw[i];
        c.mtr   = o_mtr[i];
        c.rw    = o_rw[i];
        c.br    = o_br[i];
        c.pcs   = o_pcs[i];
        c.aluop = o_aluop[i];
        c.src   = o_src[i];
        c.src1  = o_src1[i];
        c.sign  = o_sign[i];
        c.len   = o_len[i];
        c.rd    = o_rd[i];
        return c;
    endfunction

    function automatic logic [31:0] r_type(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                           logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, OP_R};
    endfunction

    function automatic logic [31:0] i_type(logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd,
                                           logic [6:0] op);
        return {12'd0, rs1, f3, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check at the falling edge, advance the model.
    task automatic step(input logic [31:0] ins, input logic v, input logic f);
        bit   hz, busyx, md, issue;
        bit   e_stall [NDUT];
        bit   e_done [NDUT];
        ctl_t nxt [NDUT];
        int   n_left [NDUT];
        inst       = ins;
        inst_valid = v;
        flush      = f;
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                m_ex[i]   = '0;
                m_left[i] = 0;
            end
            hz = v && m_ex[i].valid && m_ex[i].mr && (m_ex[i].rd != 5'd0) &&
                 ((uses_rs1(ins[6:0]) && ins[19:15] == m_ex[i].rd) ||
                  (uses_rs2(ins[6:0]) && ins[24:20] == m_ex[i].rd));
            busyx      = (m_left[i] > 0);
            md         = v && (ins[6:0] == OP_R) && (ins[31:25] == 7'd1) && cfg_en(i);
            issue      = !f && !busyx && !hz && md;
            e_stall[i] = !f && (busyx || hz);
            e_done[i]  = !f && ((busyx && m_left[i] == 1) || (cfg_lat(i) == 1 && issue));
            nxt[i]     = m_ex[i];
            n_left[i]  = m_left[i];
            if (rst) begin
                nxt[i]    = '0;
                n_left[i] = 0;
            end else if (f) begin
                nxt[i]    = '0;
                n_left[i] = 0;
            end else if (busyx) begin
                n_left[i] = m_left[i] - 1;
            end else if (hz || !v) begin
                nxt[i] = '0;
            end else begin
                nxt[i] = ref_decode(ins, cfg_en(i));
                if (md) n_left[i] = cfg_lat(i) - 1;
            end
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("ex%0d", i), 32'(obs_ctl(i)), 32'(m_ex[i]));
            chk($sformatf("stall%0d", i), 32'(o_stall[i]), 32'(e_stall[i]));
            chk($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(m_left[i] > 0));
            chk($sformatf("done%0d", i), 32'(o_done[i]), 32'(e_done[i]));
            ls_stall[i] = o_stall[i];
            ls_busy[i]  = o_busy[i];
            ls_done[i]  = o_done[i];
            m_ex[i]     = nxt[i];
            m_left[i]   = n_left[i];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lw5, add65, lw0, add60, mul7, mul9, add8, sw1, ri;
        int          n_stall, n_busy, n_done, done_at, total;
        bit          seen;

        lw5   = i_type(5'd1, 3'b010, 5'd5, OP_LD);
        add65 = r_type(7'd0, 5'd2, 5'd5, 5'd6);
        lw0   = i_type(5'd1, 3'b010, 5'd0, OP_LD);
        add60 = r_type(7'd0, 5'd2, 5'd0, 5'd6);
        mul7  = r_type(7'd1, 5'd2, 5'd1, 5'd7);
        mul9  = r_type(7'd1, 5'd2, 5'd1, 5'd9);
        add8  = r_type(7'd0, 5'd2, 5'd1, 5'd8);
        sw1   = {7'd0, 5'd3, 5'd1, 3'b010, 5'd0, OP_ST};

        for (int i = 0; i < NDUT; i++) begin
            m_ex[i]   = '0;
            m_left[i] = 0;
        end
        rst = 1'b1; inst = '0; inst_valid = 1'b0; flush = 1'b0;
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        rst = 1'b0;
        step('0, 1'b0, 1'b0);
        chk("reset_valid", 32'(o_valid[0]), 32'd0);

        // load-use: one stall, bubble, then the add reaches EX
        step(lw5, 1'b1, 1'b0);
        step(add65, 1'b1, 1'b0);
        chk("lu_stall", 32'(ls_stall[0]), 32'd1);
        chk("lu_bubble", 32'(o_valid[0]), 32'd0);
        step(add65, 1'b1, 1'b0);
        chk("lu_stall2", 32'(ls_stall[0]), 32'd0);
        chk("lu_add_rd", 32'(o_rd[0]), 32'd6);
        step(lw0, 1'b1, 1'b0);
        step(add60, 1'b1, 1'b0);
        chk("x0_nostall", 32'(ls_stall[0]), 32'd0);

        // decode spot checks
        step(i_type(5'd2, 3'b000, 5'd1, OP_JALR), 1'b1, 1'b0);
        chk("jalr_br", 32'(o_br[0]), 32'd1);
        chk("jalr_pcs", 32'(o_pcs[0]), 32'd1);
        chk("jalr_aluop", 32'(o_aluop[0]), 32'd4);
        chk("jalr_src", 32'(o_src[0]), 32'd2);
        chk("jalr_src1", 32'(o_src1[0]), 32'd1);
        step({20'h12345, 5'd3, OP_LUI}, 1'b1, 1'b0);
        chk("lui_src1", 32'(o_src1[0]), 32'd2);
        chk("lui_src", 32'(o_src[0]), 32'd1);
        step(i_type(5'd1, 3'b101, 5'd4, OP_LD), 1'b1, 1'b0);
        chk("lhu_len", 32'(o_len[0]), 32'd1);
        chk("lhu_sign", 32'(o_sign[0]), 32'd0);

        // MUL with MD_LAT=4; ENABLE_M=0 and MD_LAT=1 instances alongside
        step(mul7, 1'b1, 1'b0);
        chk("mul_aluop", 32'(o_aluop[0]), 32'd6);
        chk("nom_aluop", 32'(o_aluop[1]), 32'd0);
        chk("lat1_done", 32'(ls_done[2]), 32'd1);
        n_stall = 0; n_busy = 0; n_done = 0; done_at = -1;
        for (int k = 0; k < 4; k++) begin
            step(add8, 1'b1, 1'b0);
            n_stall += int'(ls_stall[0]);
            n_busy  += int'(ls_busy[0]);
            if (ls_done[0]) begin n_done++; done_at = k; end
            chk("nom_stall", 32'(ls_stall[1]), 32'd0);
        end
        chk("mul_stalls", 32'(n_stall), 32'd3);
        chk("mul_busy", 32'(n_busy), 32'd3);
        chk("mul_done_n", 32'(n_done), 32'd1);
        chk("mul_done_at", 32'(done_at), 32'd2);

        // flushes
        step(sw1, 1'b1, 1'b1);
        chk("flush_sw_mw", 32'(o_mw[0]), 32'd0);
        chk("flush_sw_v", 32'(o_valid[0]), 32'd0);
        step(mul7, 1'b1, 1'b0);
        step(add8, 1'b1, 1'b0);
        step(add8, 1'b1, 1'b1);
        chk("abort_done", 32'(ls_done[0]), 32'd0);
        chk("abort_stall", 32'(ls_stall[0]), 32'd0);
        chk("abort_idle", 32'(o_busy[0]), 32'd0);
        step(lw5, 1'b1, 1'b0);
        step(add65, 1'b1, 1'b1);
        chk("flush_lu_stall", 32'(ls_stall[0]), 32'd0);
        chk("flush_lu_v", 32'(o_valid[0]), 32'd0);

        // back-to-back MULs
        step(mul7, 1'b1, 1'b0);
        total = 1;
        seen  = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step(mul9, 1'b1, 1'b0);
            total++;
            seen = !ls_stall[0];
        end
        chk("b2b_issue", 32'(total), 32'd5);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step(add8, 1'b1, 1'b0);
            total++;
            seen = ls_done[0];
        end
        chk("b2b_total", 32'(total), 32'd8);
        step(add8, 1'b1, 1'b0);

        // async reset in the middle of a MUL (cnt = 2)
        step(mul7, 1'b1, 1'b0);
        step(add8, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(o_busy[0]), 32'd0);
        chk("arst_ex", 32'(obs_ctl(0)), 32'd0);
        chk("arst_stall", 32'(o_stall[0]), 32'd0);
        chk("arst_done", 32'(o_done[0]), 32'd0);
        step(add8, 1'b1, 1'b0);
        rst = 1'b0;
        step(add8, 1'b1, 1'b0);
        chk("post_rst_busy", 32'(ls_busy[0]), 32'd0);
        chk("post_rst_rd", 32'(o_rd[0]), 32'd8);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [6:0] op;
            case ($urandom_range(0, 9))
                0: op = OP_R;   1: op = OP_I;   2: op = OP_LD;  3: op = OP_ST;
                4: op = OP_BR;  5: op = OP_JAL; 6: op = OP_JALR; 7: op = OP_LUI;
                8: op = OP_AUI; default: op = 7'b1111111;
            endcase
            if ($urandom_range(0, 3) == 0) op = OP_LD;
            ri = {($urandom_range(0, 1) != 0) ? 7'd1 : 7'd0, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 3)), op};
            step(ri, $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Decode-stage control unit for the pipelined RV32 core; next generation of the combinational instruction controller.
- Decodes the IF/ID instruction into the control bundle and registers it into the ID/EX control register.
- Detects load-use hazards, applies branch/jump flushes, and sequences multi-cycle M-extension ops with a busy counter.
- Drives the stall back to PC/IF/ID and feeds the EX stage.

Parameters:
- XLEN, 32: instruction width; only 32 is legal.
- ENABLE_M, 1: 1 decodes funct7=0000001 R-type as MUL/DIV; 0 treats it as plain R-type.
- MD_LAT, 4: cycles a MUL/DIV occupies EX; must be >=1.
- CNT_W, $clog2(MD_LAT+1): busy counter width (derived).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-high
- inst_i  in  XLEN  IF/ID instruction
- inst_valid_i  in  1  IF/ID slot holds a real instruction
- flush_i  in  1  branch/jump taken in EX; kill the ID instruction
- ex_mem_read_o  out  1  registered MemRead
- ex_mem_write_o  out  1  registered MemWrite
- ex_mem_to_reg_o  out  1  registered MemtoReg
- ex_reg_write_o  out  1  registered RegWrite
- ex_branch_o  out  1  registered Branch (BTYPE/JAL/JALR)
- ex_pc_src_o  out  1  0 = PC-relative, 1 = rs1 (JALR)
- ex_alu_op_o  out  3  R=0, I=1, LS=2, BRANCH=3, J=4, U=5, MD=6
- ex_alu_src_o  out  2  operand2: REG=0, IMM=1, FOUR=2
- ex_alu_src1_o  out  2  operand1: REG=0, PC=1, ZERO=2
- ex_sign_o  out  1  load sign-extend
- ex_length_o  out  2  0 = byte, 1 = half, 2 = word
- ex_rd_o  out  5  registered rd
- ex_valid_o  out  1  EX slot holds a real instruction
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- md_busy_o  out  1  MUL/DIV in progress
- md_done_o  out  1  one-cycle pulse in the last MUL/DIV cycle

Behaviour:
- Decode (combinational, same per-opcode mapping as the current controller):
  - RegWrite = 0 for STYPE/BTYPE.
  - ALUSrc = REG for RTYPE/BTYPE; IMM for IARITH/ILOAD/STYPE/LUI/AUIPC; FOUR otherwise.
  - ALUSrc1 = REG for RTYPE/IARITH/ILOAD/STYPE/BTYPE; ZERO for LUI; PC otherwise.
  - length: funct3 010 -> 2; 001/101 -> 1; else 0.
  - sign = ~funct3[2].
  - MD op: ENABLE_M && opcode RTYPE && funct7 = 0000001; alu_op = MD.
- rs1 used by RTYPE, IARITH, ILOAD, STYPE, BTYPE, JALR. rs2 used by RTYPE, STYPE, BTYPE.
- Load-use hazard:
  - Fires when ex_valid_o && ex_mem_read_o && ex_rd_o != 0 && ex_rd_o matches a used rs of a valid ID instruction.
  - Response: stall_o = 1 for one cycle; a bubble is written to ID/EX.
- Bubble: ex_valid_o = 0 with all of mem_read, mem_write, reg_write, branch = 0; other fields don't-care but held at 0.
- State machine:
  - IDLE: a valid, non-hazard, non-flushed MD op is registered into ID/EX with cnt <= MD_LAT-1. Go to BUSY if MD_LAT > 1.
  - BUSY: stall_o = 1; ID/EX holds its contents; cnt decrements each cycle. md_done_o = 1 when cnt == 1; the next cycle returns to IDLE with cnt = 0.
  - MD_LAT = 1: md_done_o pulses in the issue cycle; BUSY is never entered.
- Priority at a clock edge: rst > flush_i > BUSY hold > load-use bubble > normal load.
  - flush_i writes a bubble and overrides stall.
  - flush_i in BUSY aborts the op: cnt <= 0, IDLE, no md_done_o.
- Invalid ID: inst_valid_i = 0 loads a bubble; no hazard and no stall.
- Reset: all ex_* outputs 0, state IDLE, cnt 0, md_busy_o 0, md_done_o 0; stall_o evaluates to 0 when no ID instruction is valid.
- md_busy_o = (state == BUSY). All ex_* outputs are registered; stall_o and md_done_o are combinational from state/cnt/inputs.

Test Plan:
- Reset then idle: rst = 1 mid-operation with cnt = 2 -> all outputs 0 asynchronously; IDLE after release.
- Load-use: `lw x5,0(x1)` then `add x6,x5,x2` -> stall_o = 1 for exactly one cycle; ex_valid_o = 0 bubble; add reaches EX the following cycle. Same sequence with rd = x0 -> no stall.
- Decode spot checks:
  - `jalr x1,0(x2)` -> branch = 1, pc_src = 1, alu_op = 4, alu_src = 2, alu_src1 = 1.
  - `lui` -> alu_src1 = 2, alu_src = 1.
  - `lhu` -> length = 1, sign = 0.
- MUL with MD_LAT = 4 -> md_busy_o high 3 cycles, stall_o high 3 cycles, md_done_o one pulse in the 4th cycle. With ENABLE_M = 0 the same instruction gives alu_op = 0 and no stall.
- Flush: flush_i with a valid `sw` in ID -> bubble, no mem_write. flush_i in the 2nd BUSY cycle -> IDLE next cycle, no md_done_o. flush_i coinciding with a load-use hazard -> bubble, stall_o = 0.
- Back-to-back: two MULs -> the second issues the cycle after the first's md_done_o; total 8 cycles with MD_LAT = 4.
